imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single-port 1024x32 instruction memory between two requesters: the CPU instruction-fetch port (read-only) and the loader/debug port (read/write, byte-enabled).
- Drives the memory's Avalon-style slave signals.
- Tracks the memory's 1-cycle read latency and returns read data to the correct requester.
- Provides a LOAD mode that gives the loader exclusive ownership while a program image is written.

Parameters:
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- MAX_WAIT, 8, loader starvation limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- freeze  in  1  when high, no new grants are issued
- load_mode  in  1  request exclusive loader ownership
- load_active  out  1  high while in LOAD state
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  loader request
- d_we  in  1  loader write (1) / read (0)
- d_addr  in  ADDR_W  loader word address
- d_be  in  BE_W  loader byte enables
- d_wdata  in  DATA_W  loader write data
- d_gnt  out  1  loader request accepted this cycle
- d_rvalid  out  1  loader read data valid
- d_rdata  out  DATA_W  loader read data
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  BE_W  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_debugaccess  out  1  to memory; write qualifier
- mem_clken  out  1  to memory; tied 1
- mem_readdata  in  DATA_W  from memory, valid 1 cycle after address

Behaviour:
- Reset (async): state=RUN; f_rvalid=d_rvalid=0; load_active=0; wait counter=0.
- Grants are combinational and apply in the same cycle as the request. mem_* signals are combinational from the winner. When there is no winner: chipselect=0, write=0, address/be/wdata=0.
- Accepted requests (gnt=1) are never pending; requesters hold req until gnt.
- freeze=1: f_gnt=d_gnt=0. In-flight rvalid still completes.
- FSM states:
  - RUN: fetch has priority over loader. f_gnt=f_req. d_gnt=d_req & ~f_req.
  - DRAIN: entered from RUN when load_mode=1. No new grants. Leaves after exactly 1 cycle, so any outstanding read completes. Goes to LOAD, or back to RUN if load_mode has dropped.
  - LOAD: f_gnt=0. d_gnt=d_req. load_active=1. Returns to RUN on load_mode=0, with no drain needed on exit.
- Loader write: mem_write=1, mem_debugaccess=1, mem_byteenable=d_be. Fetch and loader reads: mem_write=0, mem_debugaccess=0, mem_byteenable=all ones.
- Read latency: x_rvalid is registered and goes high exactly 1 cycle after a granted read. x_rdata=mem_readdata while rvalid, else 0. Writes produce no rvalid.
- Back-to-back reads: one grant per cycle; rvalid is asserted on consecutive cycles.
- Simultaneous f_req and d_req in RUN: fetch wins (unless the optional feature overrides).
- load_mode asserted during a fetch grant: that fetch's rvalid is still delivered, in DRAIN.

Optional Feature:
- Macro IMEM_ARB_FAIRNESS_EN.
- Defined:
  - In RUN, a counter increments each cycle d_req=1 & d_gnt=0 and clears on d_gnt.
  - When count==MAX_WAIT-1, the next conflicting cycle grants the loader instead of fetch, and the counter clears.
- Undefined: strict fetch priority; the counter is not synthesised.

Decomposition:
- Package imem_arb_pkg: ADDR_W/DATA_W/BE_W constants and the state enum {RUN, DRAIN, LOAD}.
- Sub-module imem_arb_wait_ctr: saturating starvation counter, instantiated only under IMEM_ARB_FAIRNESS_EN.

Test Plan:
- Reset pulse mid-read: f_rvalid=0 and state=RUN immediately, asynchronously.
- f_req with f_addr=0x010, memory word 0x00000013: f_gnt same cycle; f_rvalid=1 next cycle with f_rdata=0x00000013.
- Simultaneous f_req and d_req for 3 cycles (feature off): f_gnt=1 each cycle; d_gnt=0 until f_req drops, then d_gnt=1.
- load_mode=1 during a fetch read: DRAIN 1 cycle with f_rvalid=1. Then load_active=1. Loader write d_addr=0x3FF, d_be=0x3, d_wdata=0xDEADBEEF, then a read of 0x3FF: d_rdata=0x0000BEEF (bytes 3:2 from prior contents 0).
- freeze=1 with both requests pending: no grant, chipselect=0. Grants resume the cycle freeze drops.
- With IMEM_ARB_FAIRNESS_EN and MAX_WAIT=8: continuous f_req and d_req give d_gnt=1 on the 8th conflicting cycle, then fetch priority resumes.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared constants and FSM state type for the instruction-memory port arbiter.
package imem_arb_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned MAX_WAIT = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/imem_arb_wait_ctr.sv
// Saturating loader starvation counter; at_limit_o is high once MAX_WAIT-1
// un-granted loader cycles have accumulated.
module imem_arb_wait_ctr #(
    parameter int unsigned MAX_WAIT = imem_arb_pkg::MAX_WAIT,
    localparam int unsigned CNT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             at_limit_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            at_limit_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            at_limit_q <= (count_d == LIMIT);
        end
    end

    assign at_limit_o = at_limit_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch and the
// loader/debug port. Optional loader fairness: define IMEM_ARB_FAIRNESS_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              load_mode,
    output logic              load_active,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BE_W-1:0]   d_be,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_debugaccess,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    arb_state_e state_q, state_d;
    logic       f_rvalid_q, d_rvalid_q, load_active_q;
    logic       loader_turn;

`ifdef IMEM_ARB_FAIRNESS_EN
    imem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .inc_i      ((state_q == RUN) && d_req && !d_gnt),
        .clr_i      (d_gnt),
        .at_limit_o (loader_turn)
    );
`else
    assign loader_turn = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            f_rvalid_q    <= 1'b0;
            d_rvalid_q    <= 1'b0;
            load_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_rvalid_q    <= f_gnt;
            d_rvalid_q    <= d_gnt && !d_we;
            load_active_q <= (state_d == LOAD);
        end
    end

    // DRAIN lasts one cycle so a read granted in RUN returns before LOAD
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (load_mode)  state_d = DRAIN;
            DRAIN:   state_d = load_mode ? LOAD : RUN;
            LOAD:    if (!load_mode) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        f_gnt           = 1'b0;
        d_gnt           = 1'b0;
        mem_address     = '0;
        mem_byteenable  = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = '0;
        mem_debugaccess = 1'b0;
        if (!freeze) begin
            case (state_q)
                RUN: begin
                    if (loader_turn && d_req) begin
                        d_gnt = 1'b1;
                    end else begin
                        f_gnt = f_req;
                        d_gnt = d_req && !f_req;
                    end
                end
                LOAD:    d_gnt = d_req;
                default: ;
            endcase
        end
        if (f_gnt) begin
            mem_chipselect = 1'b1;
            mem_address    = f_addr;
            mem_byteenable = '1;
        end else if (d_gnt) begin
            mem_chipselect  = 1'b1;
            mem_address     = d_addr;
            mem_write       = d_we;
            mem_debugaccess = d_we;
            mem_byteenable  = d_we ? d_be : '1;
            mem_writedata   = d_wdata;
        end
    end

    assign mem_clken   = 1'b1;
    assign load_active = load_active_q;
    assign f_rvalid    = f_rvalid_q;
    assign d_rvalid    = d_rvalid_q;
    assign f_rdata     = f_rvalid_q ? mem_readdata : '0;
    assign d_rdata     = d_rvalid_q ? mem_readdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a 1-cycle byte-enabled memory model.
module tb_imem_port_arbiter;
    import imem_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset, freeze, load_mode, load_active;
    logic              f_req, f_gnt, f_rvalid;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [ADDR_W-1:0] d_addr;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;

    logic [DATA_W-1:0] mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_port_arbiter dut (
        .clk(clk), .reset(reset), .freeze(freeze), .load_mode(load_mode),
        .load_active(load_active),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_debugaccess(mem_debugaccess),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Memory model: contents loaded while reset is held, then byte-enabled writes and 1-cycle reads
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[16] <= 32'h0000_0013;
            mem[17] <= 32'h0000_0093;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= mem[mem_address];
        end
    end

    task automatic idle_inputs();
        freeze = 1'b0; load_mode = 1'b0; f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_f_rvalid: got %b want 0", f_rvalid); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_d_rvalid: got %b want 0", d_rvalid); end
        n_cmp++; if (load_active !== 1'b0) begin n_err++; $display("FAIL reset_load_active: got %b want 0", load_active); end
        n_cmp++; if (mem_chipselect !== 1'b0) begin n_err++; $display("FAIL reset_cs: got %b want 0", mem_chipselect); end
        n_cmp++; if (mem_clken !== 1'b1) begin n_err++; $display("FAIL reset_clken: got %b want 1", mem_clken); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        f_req = 1'b1; f_addr = 10'h010;
        #1;
        n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL fetch_gnt: got %b want 1", f_gnt); end
        n_cmp++; if (mem_address !== 10'h010) begin n_err++; $display("FAIL fetch_addr: got %h want 010", mem_address); end
        n_cmp++; if ({mem_chipselect, mem_write, mem_debugaccess, mem_byteenable} !== 7'b100_1111) begin
            n_err++; $display("FAIL fetch_mem_ctl: got %b want 1001111", {mem_chipselect, mem_write, mem_debugaccess, mem_byteenable}); end
        @(posedge clk); #1;
        n_cmp++; if (f_rvalid !== 1'b1) begin n_err++; $display("FAIL fetch_rvalid: got %b want 1", f_rvalid); end
        n_cmp++; if (f_rdata !== 32'h0000_0013) begin n_err++; $display("FAIL fetch_rdata: got %h want 00000013", f_rdata); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_d_rvalid: got %b want 0", d_rvalid); end
        @(negedge clk);
        f_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({f_rvalid, f_rdata} !== 33'h0) begin n_err++; $display("FAIL fetch_idle: got %b/%h want 0/0", f_rvalid, f_rdata); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        f_req = 1'b1; f_addr = 10'h011; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({f_gnt, d_gnt} !== 2'b10) begin n_err++; $display("FAIL prio_cycle%0d: got f%b d%b want f1 d0", i, f_gnt, d_gnt); end
            @(negedge clk);
        end
        f_req = 1'b0;
        #1;
        n_cmp++; if ({f_gnt, d_gnt} !== 2'b01) begin n_err++; $display("FAIL prio_loader: got f%b d%b want f0 d1", f_gnt, d_gnt); end
        n_cmp++; if (mem_address !== 10'h005) begin n_err++; $display("FAIL prio_loader_addr: got %h want 005", mem_address); end
        @(posedge clk); #1;
        n_cmp++; if ({f_rvalid, d_rvalid} !== 2'b01) begin n_err++; $display("FAIL prio_rvalid: got f%b d%b want f0 d1", f_rvalid, d_rvalid); end
        @(negedge clk);
        d_req = 1'b0;
        @(posedge clk);
    endtask

`ifdef IMEM_ARB_FAIRNESS_EN
    task automatic test_fairness();
        @(negedge clk);
        f_req = 1'b1; f_addr = 10'h010; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
        for (int i = 1; i <= 10; i++) begin
            #1;
            n_cmp++; if ({f_gnt, d_gnt} !== ((i == 8) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL fair_cycle%0d: got f%b d%b want f%b d%b", i, f_gnt, d_gnt, i != 8, i == 8); end
            @(negedge clk);
        end
        f_req = 1'b0; d_req = 1'b0;
        @(posedge clk);
    endtask
`endif

    task automatic test_back_to_back();
        @(negedge clk);
        f_req = 1'b1; f_addr = 10'h010;
        @(posedge clk); #1;
        n_cmp++; if ({f_rvalid, f_rdata} !== {1'b1, 32'h0000_0013}) begin n_err++; $display("FAIL b2b_first: got %b/%h want 1/00000013", f_rvalid, f_rdata); end
        @(negedge clk);
        f_addr = 10'h011;
        @(posedge clk); #1;
        n_cmp++; if ({f_rvalid, f_rdata} !== {1'b1, 32'h0000_0093}) begin n_err++; $display("FAIL b2b_second: got %b/%h want 1/00000093", f_rvalid, f_rdata); end
        @(negedge clk);
        f_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", f_rvalid); end
    endtask

    task automatic test_freeze();
        @(negedge clk);
        freeze = 1'b1; f_req = 1'b1; f_addr = 10'h010; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if ({f_gnt, d_gnt, mem_chipselect} !== 3'b000) begin
                n_err++; $display("FAIL freeze_cycle%0d: got f%b d%b cs%b want 000", i, f_gnt, d_gnt, mem_chipselect); end
            n_cmp++; if (mem_address !== 10'h000) begin n_err++; $display("FAIL freeze_addr%0d: got %h want 000", i, mem_address); end
            @(posedge clk); #1;
            n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL freeze_rvalid%0d: got %b want 0", i, f_rvalid); end
            @(negedge clk);
        end
        freeze = 1'b0;
        #1;
        n_cmp++; if ({f_gnt, d_gnt, mem_chipselect} !== 3'b101) begin
            n_err++; $display("FAIL unfreeze: got f%b d%b cs%b want 101", f_gnt, d_gnt, mem_chipselect); end
        @(negedge clk);
        f_req = 1'b0; d_req = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_load();
        @(negedge clk);
        f_req = 1'b1; f_addr = 10'h010; load_mode = 1'b1;
        #1;
        n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL load_fetch_gnt: got %b want 1", f_gnt); end
        @(posedge clk); #1;
        n_cmp++; if ({f_rvalid, f_rdata} !== {1'b1, 32'h0000_0013}) begin n_err++; $display("FAIL drain_rvalid: got %b/%h want 1/00000013", f_rvalid, f_rdata); end
        n_cmp++; if (load_active !== 1'b0) begin n_err++; $display("FAIL drain_load_active: got %b want 0", load_active); end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_be = 4'h3; d_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if ({f_gnt, d_gnt, mem_chipselect} !== 3'b000) begin
            n_err++; $display("FAIL drain_no_gnt: got f%b d%b cs%b want 000", f_gnt, d_gnt, mem_chipselect); end
        @(posedge clk); #1;
        n_cmp++; if ({load_active, f_rvalid} !== 2'b10) begin n_err++; $display("FAIL load_enter: got la%b fv%b want 10", load_active, f_rvalid); end
        @(negedge clk); #1;
        n_cmp++; if ({f_gnt, d_gnt, mem_write, mem_debugaccess} !== 4'b0111) begin
            n_err++; $display("FAIL load_write_ctl: got %b want 0111", {f_gnt, d_gnt, mem_write, mem_debugaccess}); end
        n_cmp++; if ({mem_byteenable, mem_writedata} !== {4'h3, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL load_write_data: got %h/%h want 3/deadbeef", mem_byteenable, mem_writedata); end
        @(posedge clk); #1;
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL load_write_rvalid: got %b want 0", d_rvalid); end
        @(negedge clk);
        d_we = 1'b0; d_be = 4'hF;
        #1;
        n_cmp++; if ({d_gnt, mem_write, mem_debugaccess, mem_byteenable} !== 7'b100_1111) begin
            n_err++; $display("FAIL load_read_ctl: got %b want 1001111", {d_gnt, mem_write, mem_debugaccess, mem_byteenable}); end
        @(posedge clk); #1;
        n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000_BEEF}) begin n_err++; $display("FAIL load_readback: got %b/%h want 1/0000beef", d_rvalid, d_rdata); end
        @(negedge clk);
        d_req = 1'b0; f_req = 1'b0; load_mode = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({load_active, d_rvalid} !== 2'b00) begin n_err++; $display("FAIL load_exit: got la%b dv%b want 00", load_active, d_rvalid); end
        @(negedge clk);
        f_req = 1'b1;
        #1;
        n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL run_after_load: got %b want 1", f_gnt); end
        @(negedge clk);
        f_req = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        load_mode = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF; d_be = 4'hF;
        @(posedge clk); #1;
        n_cmp++; if ({load_active, d_rvalid} !== 2'b11) begin n_err++; $display("FAIL pre_reset: got la%b dv%b want 11", load_active, d_rvalid); end
        d_req = 1'b0; f_req = 1'b1; f_addr = 10'h010;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if ({load_active, d_rvalid, f_rvalid} !== 3'b000) begin
            n_err++; $display("FAIL async_reset: got la%b dv%b fv%b want 000", load_active, d_rvalid, f_rvalid); end
        n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL reset_state_run: got f_gnt %b want 1", f_gnt); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_priority();
`ifdef IMEM_ARB_FAIRNESS_EN
        test_fairness();
`endif
        test_back_to_back();
        test_freeze();
        test_load();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
